mem: RTL and testbench
======================

# mem

Memory-access pipeline stage of the single-issue MIPS core, between EX and WB. It registers the EX→MEM bus and waits for the data-SRAM response of any load or store issued in EX. It aligns and extends load data, then presents the 274-bit MEM→WB bus that WB registers. It also raises a stall request while a response is outstanding and drives the MEM forwarding path to ID.

## Interface
- Parameters: none; widths come from shared defines (EX_TO_MEM_WD = 310, MEM_TO_WB_WD = 274).
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- flush  in  1  exception flush; bubbles the stage
- stall  in  10  pipeline stall vector; Stop = 1; stage uses stall[7] and stall[8]
- ex_to_mem_bus  in  310  {mem_op[3:0], rt_val[31:0], mem_to_wb-layout[273:0]}
- data_sram_data_ok  in  1  one-cycle response strobe for the outstanding request
- data_sram_rdata  in  32  load data, valid with data_ok
- mem_to_wb_bus  out  274  {cp0_bus41, cp0_epc32, in_delayslot1, bad_vaddr32, excepttype32, hilo66, pc32, rf_we1, rf_waddr5, rf_wdata32}
- stallreq_mem  out  1  request to ctrl to stop stall[8:0]
- mem_fwd_bus  out  38  {rf_we, rf_waddr, rf_wdata} after load alignment, to ID bypass

## Operation
- Input register r, loaded on posedge clk with this priority:
  - rst or flush → r = 0.
  - stall[7]=Stop and stall[8]=NoStop → r = 0 (bubble).
  - stall[7]=NoStop → r = ex_to_mem_bus.
  - Otherwise r holds.
- mem_op encodings: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LWL, 10 LWR.
- A memop instruction has mem_op≠0 and excepttype==0. Only memops had requests issued in EX.
- The low address bits a = r.rf_wdata[1:0], which EX sets to the effective address. Little-endian.
- Load data source: data_sram_rdata in WAIT; the buffer in HOLD.
- Load results:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: the full word.
  - LWL/LWR: merged with rt_val per the MIPS32 rules.
- Store result: rf_wdata passes through unchanged, with rf_we as supplied.
- FSM states: IDLE, WAIT, HOLD, DROP.
  - IDLE: if r holds a memop → WAIT.
  - WAIT: stallreq_mem = ~data_ok.
    - data_ok and stall[8]=NoStop → IDLE, or WAIT if the newly loaded r is a memop.
    - data_ok and stall[8]=Stop → capture rdata into buf, go HOLD.
  - HOLD: stallreq_mem = 0; output is taken from buf; stall[8]=NoStop → IDLE/WAIT as above.
  - flush in WAIT without data_ok → DROP.
  - DROP: stallreq_mem = 1 if r holds a memop.
    - The next data_ok is discarded; then → WAIT if r holds a memop, else IDLE.
- flush in IDLE or HOLD → IDLE.
- mem_to_wb_bus is r with rf_wdata replaced by the aligned result.
- While stallreq_mem = 1, mem_to_wb_bus.rf_we is forced to 0, and so is mem_fwd_bus.

## Timing
- Reset values: r = 0, state IDLE, buf = 0, all outputs 0.
- Zero-wait response (data_ok in the first cycle r holds the load): the result is on mem_to_wb_bus that cycle. WB registers it at the next edge.
- N-cycle response: stallreq_mem is high for N cycles, combinationally from state and data_ok.
- At most one request is outstanding. EX must not issue while stallreq_mem = 1.
- Simultaneous flush and data_ok in WAIT: the response is consumed and the state → IDLE; the instruction is squashed.
- rst mid-WAIT: the state → IDLE. Any late response is the SRAM bridge's reset responsibility.

## Configuration
- LWLR_EN defined: LWL/LWR merge logic is present.
- LWLR_EN undefined:
  - codes 9/10 behave as LW for handshake purposes;
  - rf_wdata passes rt_val unchanged;
  - the decoder never emits these codes.

## Structure
- Shared defines header holds:
  - EX_TO_MEM_WD and MEM_TO_WB_WD;
  - mem_op codes;
  - Stop/NoStop;
  - FSM state encodings.
- One sub-module, mem_load_align: combinational; takes (mem_op, a, rdata, rt_val) and returns the 32-bit result.

## Test plan
- LB: a=2, rdata=0x12_80_34_56, data_ok same cycle → rf_wdata=0xFFFFFF80, stallreq_mem never high.
- LHU: a=2, rdata=0x8001_0000, data_ok after 3 cycles → stallreq_mem high for 3 cycles with rf_we=0; then rf_wdata=0x00008001.
- LW returns while stall[8]=Stop for 2 cycles → HOLD; after release the output is 0xDEADBEEF even though data_sram_rdata changed meanwhile.
- flush in WAIT, then a new LW enters before the stale data_ok → stale 0x11111111 discarded; the next response 0x22222222 is delivered.
- stall[7]=Stop with stall[8]=NoStop → mem_to_wb_bus=0 next cycle. stall[7] and stall[8] both Stop → r holds.
- LWLR_EN defined: LWL a=1, rdata=0xAABBCCDD, rt=0x11223344 → 0xCCDD3344. LWLR_EN undefined: same stimulus → 0x11223344.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the MEM pipeline stage.
//   Bus widths, mem_op encodings, Stop/NoStop stall levels, FSM state
//   encoding and bus field positions. Helpers classify an EX->MEM bus
//   entry as a memory-access instruction or as a load.
// Configuration macro: LWLR_EN (consumed by mem_load_align).
package mem_pkg;

  localparam int EX_TO_MEM_WD = 310;
  localparam int MEM_TO_WB_WD = 274;

  // mem_op encodings
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;
  localparam logic [3:0] MEM_OP_LWL  = 4'd9;
  localparam logic [3:0] MEM_OP_LWR  = 4'd10;

  // stall vector levels
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // field positions inside the EX->MEM bus (MEM->WB layout sits in the low 274 bits)
  localparam int RF_WE_BIT  = 37;
  localparam int EXCEPT_LSB = 136;
  localparam int RT_LSB     = 274;
  localparam int OP_LSB     = 306;

  // A request was issued in EX only for a memory op without a pending exception.
  function automatic logic is_memop(input logic [EX_TO_MEM_WD-1:0] bus);
    return (bus[OP_LSB +: 4] != MEM_OP_NONE) && (bus[EXCEPT_LSB +: 32] == 32'd0);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    logic ld;
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU,
      MEM_OP_LW, MEM_OP_LWL, MEM_OP_LWR: ld = 1'b1;
      default:                           ld = 1'b0;
    endcase
    return ld;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align -- combinational little-endian load data alignment.
//   mem_op [3:0]  load opcode
//   a      [1:0]  low effective-address bits
//   rdata  [31:0] word returned by the data SRAM
//   rt_val [31:0] old rt value (merged by LWL/LWR)
//   result [31:0] aligned, extended or merged load result
// Configuration macro: LWLR_EN -- when undefined, LWL/LWR return rt_val unchanged.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_val,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (a)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

`ifdef LWLR_EN
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // LWL fills the upper a+1 bytes from memory; LWR fills the lower 4-a bytes.
  always_comb begin
    case (a)
      2'd0:    begin lwl_val = {rdata[7:0],  rt_val[23:0]}; lwr_val = rdata;                         end
      2'd1:    begin lwl_val = {rdata[15:0], rt_val[15:0]}; lwr_val = {rt_val[31:24], rdata[31:8]};  end
      2'd2:    begin lwl_val = {rdata[23:0], rt_val[7:0]};  lwr_val = {rt_val[31:16], rdata[31:16]}; end
      2'd3:    begin lwl_val = rdata;                        lwr_val = {rt_val[31:8],  rdata[31:24]}; end
      default: begin lwl_val = rdata;                        lwr_val = rdata;                         end
    endcase
  end
`endif

  always_comb begin
    result = rdata;
    case (mem_op)
      MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: result = {24'd0, byte_sel};
      MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: result = {16'd0, half_sel};
      MEM_OP_LW:  result = rdata;
`ifdef LWLR_EN
      MEM_OP_LWL: result = lwl_val;
      MEM_OP_LWR: result = lwr_val;
`else
      MEM_OP_LWL, MEM_OP_LWR: result = rt_val;
`endif
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/mem.sv
// mem -- memory-access stage between EX and WB.
//   clk, rst            clock; synchronous active-high reset
//   flush               exception flush, bubbles the stage
//   stall [9:0]         stall vector (Stop=1); stall[7] stops this stage's
//                       input register, stall[8] stops WB
//   ex_to_mem_bus [309:0] {mem_op, rt_val, MEM->WB layout}
//   data_sram_data_ok   one-cycle response strobe
//   data_sram_rdata     load data, valid with data_ok
//   mem_to_wb_bus [273:0] registered input with rf_wdata replaced by the load result
//   stallreq_mem        asks ctrl to stop stall[8:0] while a response is owed
//   mem_fwd_bus [37:0]  {rf_we, rf_waddr, rf_wdata} to the ID bypass
// Configuration macro: LWLR_EN (LWL/LWR merge logic in mem_load_align).
module mem
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [9:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    stallreq_mem,
  output logic [37:0]             mem_fwd_bus
);

  logic [EX_TO_MEM_WD-1:0] r_q, r_d;
  state_e                  state_q, state_d;
  logic [31:0]             hold_q, hold_d;
  logic [31:0]             load_src;
  logic [31:0]             align_result;
  logic [MEM_TO_WB_WD-1:0] wb_bus;
  logic                    stall_unused;

  assign stall_unused = ^{stall[9], stall[6:0]};

  // Input register next value: flush, then bubble, then load, else hold.
  always_comb begin
    r_d = r_q;
    if (flush) begin
      r_d = '0;
    end else if ((stall[7] == STOP) && (stall[8] == NO_STOP)) begin
      r_d = '0;
    end else if (stall[7] == NO_STOP) begin
      r_d = ex_to_mem_bus;
    end else begin
      r_d = r_q;
    end
  end

  // Response-tracking FSM. Leaving a state goes to WAIT whenever the entry
  // being loaded into r is a memop, since its request was issued in EX.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    stallreq_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_memop(r_d)) state_d = ST_WAIT;
        else               state_d = ST_IDLE;
      end
      ST_WAIT: begin
        stallreq_mem = ~data_sram_data_ok;
        if (data_sram_data_ok) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (stall[8] == STOP) begin
            state_d = ST_HOLD;
            hold_d  = data_sram_rdata;
          end else begin
            state_d = is_memop(r_d) ? ST_WAIT : ST_IDLE;
          end
        end else if (flush) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush)                     state_d = ST_IDLE;
        else if (stall[8] == NO_STOP)  state_d = is_memop(r_d) ? ST_WAIT : ST_IDLE;
        else                           state_d = ST_HOLD;
      end
      ST_DROP: begin
        // The squashed request's response is still owed; swallow it.
        stallreq_mem = is_memop(r_q);
        if (data_sram_data_ok) state_d = is_memop(r_d) ? ST_WAIT : ST_IDLE;
        else                   state_d = ST_DROP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, input register and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      state_q <= ST_IDLE;
      hold_q  <= 32'd0;
    end else begin
      r_q     <= r_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign load_src = (state_q == ST_HOLD) ? hold_q : data_sram_rdata;

  mem_load_align u_load_align (
    .mem_op (r_q[OP_LSB +: 4]),
    .a      (r_q[1:0]),
    .rdata  (load_src),
    .rt_val (r_q[RT_LSB +: 32]),
    .result (align_result)
  );

  // Output bus: loads replace rf_wdata; write enable suppressed while stalling.
  always_comb begin
    wb_bus = r_q[MEM_TO_WB_WD-1:0];
    if (is_load(r_q[OP_LSB +: 4])) wb_bus[31:0] = align_result;
    else                           wb_bus[31:0] = r_q[31:0];
    if (stallreq_mem) wb_bus[RF_WE_BIT] = 1'b0;
    else              wb_bus[RF_WE_BIT] = r_q[RF_WE_BIT];
  end

  assign mem_to_wb_bus = wb_bus;
  assign mem_fwd_bus   = wb_bus[37:0];

endmodule

// File: tb/tb_mem.sv
// tb_mem -- self-checking bench for the MEM stage: directed vector table,
// hand-written multi-cycle sequences and randomized loads/stores checked
// against an arithmetic reference model.
module tb_mem;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [9:0]   stall;
  logic [9:0]   stall_drv;
  logic [309:0] ex_bus;
  logic         data_ok;
  logic [31:0]  rdata_in;
  logic [273:0] mem_to_wb_bus;
  logic         stallreq_mem;
  logic [37:0]  mem_fwd_bus;

  int n_checks = 0;
  int n_errors = 0;

  // Minimal ctrl model: a MEM stall request stops stall[8:0].
  assign stall = stall_drv | (stallreq_mem ? 10'h1FF : 10'h000);

  mem dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall             (stall),
    .ex_to_mem_bus     (ex_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata_in),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .stallreq_mem      (stallreq_mem),
    .mem_fwd_bus       (mem_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] rt;
    int          lat;
    int          hold;
    logic [31:0] exp;
  } vec_t;

`ifdef LWLR_EN
  localparam logic [31:0] EXP_LWL = 32'hCCDD3344;
  localparam logic [31:0] EXP_LWR = 32'h1122AABB;
`else
  localparam logic [31:0] EXP_LWL = 32'h11223344;
  localparam logic [31:0] EXP_LWR = 32'h11223344;
`endif

  task automatic check(input string name, input logic [273:0] act, input logic [273:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_ld(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || op == 4'd9 || op == 4'd10;
  endfunction

  function automatic logic [309:0] mk_bus(input logic [3:0] op, input logic [31:0] rt,
                                          input logic [31:0] wdata, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] pc);
    return {op, rt, {9'd0, pc}, ~pc, pc[2], pc ^ 32'h5A5A5A5A, 32'd0,
            {pc, ~pc, 2'b01}, pc, we, waddr, wdata};
  endfunction

  // Reference: byte/half extraction by shifting; LWL/LWR as byte-mask merges.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd, input logic [31:0] rt);
    int          sh;
    int          hs;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] res;
    sh = 8 * int'(addr[1:0]);
    hs = addr[1] ? 16 : 0;
    b  = (rd >> sh) & 32'h000000FF;
    h  = (rd >> hs) & 32'h0000FFFF;
    case (op)
      4'd1:    res = b[7]  ? (b | 32'hFFFFFF00) : b;
      4'd2:    res = b;
      4'd3:    res = h[15] ? (h | 32'hFFFF0000) : h;
      4'd4:    res = h;
      4'd5:    res = rd;
`ifdef LWLR_EN
      4'd9:    res = (rd << (24 - sh)) | (rt & ((32'h1 << (24 - sh)) - 32'h1));
      4'd10:   res = (rd >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
`else
      4'd9:    res = rt;
      4'd10:   res = rt;
`endif
      default: res = addr;
    endcase
    return res;
  endfunction

  // One memory instruction: issue, lat wait cycles, response, hold cycles, bubble.
  task automatic run_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] rt, input logic [31:0] exp,
                         input int lat, input int hold);
    logic [309:0] bus;
    logic [273:0] exp_wb;
    logic         we;
    we     = is_ld(op) ? 1'b1 : 1'($urandom % 2);
    bus    = mk_bus(op, rt, addr, we, 5'($urandom), $urandom);
    exp_wb = bus[273:0];
    exp_wb[31:0] = exp;
    ex_bus = bus; stall_drv = 10'h000; data_ok = 1'b0; flush = 1'b0;
    @(negedge clk);
    ex_bus = '0;
    for (int i = 0; i < lat; i++) begin
      data_ok = 1'b0; rdata_in = $urandom; #1;
      check({name, " stallreq_wait"}, 274'(stallreq_mem), 274'(1'b1));
      check({name, " we_masked"}, 274'({mem_to_wb_bus[37], mem_fwd_bus[37]}), 274'(2'b00));
      @(negedge clk);
    end
    data_ok = 1'b1; rdata_in = rd;
    stall_drv = (hold > 0) ? 10'h180 : 10'h000;
    #1;
    check({name, " stallreq_resp"}, 274'(stallreq_mem), 274'(1'b0));
    check({name, " wb_resp"}, mem_to_wb_bus, exp_wb);
    check({name, " fwd_resp"}, 274'(mem_fwd_bus), 274'(exp_wb[37:0]));
    @(negedge clk);
    data_ok = 1'b0;
    for (int h = 1; h <= hold; h++) begin
      rdata_in = $urandom;
      if (h == hold) stall_drv = 10'h000;
      #1;
      check({name, " wb_hold"}, mem_to_wb_bus, exp_wb);
      check({name, " stallreq_hold"}, 274'(stallreq_mem), 274'(1'b0));
      @(negedge clk);
    end
    stall_drv = 10'h000; #1;
    check({name, " bubble_after"}, mem_to_wb_bus, 274'(0));
  endtask

  vec_t         vecs[9];
  logic [309:0] alu;
  logic [309:0] lwa;
  logic [309:0] lwb;
  logic [273:0] exp_b;

  initial begin
    vecs[0] = '{op: 4'd1,  addr: 32'h00001002, rdata: 32'h12803456, rt: 32'h0,        lat: 0, hold: 0, exp: 32'hFFFFFF80};
    vecs[1] = '{op: 4'd4,  addr: 32'h00002002, rdata: 32'h80010000, rt: 32'h0,        lat: 3, hold: 0, exp: 32'h00008001};
    vecs[2] = '{op: 4'd5,  addr: 32'h00003000, rdata: 32'hDEADBEEF, rt: 32'h0,        lat: 1, hold: 2, exp: 32'hDEADBEEF};
    vecs[3] = '{op: 4'd2,  addr: 32'h00004001, rdata: 32'h12803456, rt: 32'h0,        lat: 0, hold: 0, exp: 32'h00000034};
    vecs[4] = '{op: 4'd3,  addr: 32'h00005000, rdata: 32'h1234F00F, rt: 32'h0,        lat: 2, hold: 0, exp: 32'hFFFFF00F};
    vecs[5] = '{op: 4'd8,  addr: 32'h00001004, rdata: 32'h99999999, rt: 32'h0,        lat: 1, hold: 0, exp: 32'h00001004};
    vecs[6] = '{op: 4'd9,  addr: 32'h00006001, rdata: 32'hAABBCCDD, rt: 32'h11223344, lat: 0, hold: 0, exp: EXP_LWL};
    vecs[7] = '{op: 4'd10, addr: 32'h00007002, rdata: 32'hAABBCCDD, rt: 32'h11223344, lat: 1, hold: 0, exp: EXP_LWR};
    vecs[8] = '{op: 4'd1,  addr: 32'h00008003, rdata: 32'h7F000000, rt: 32'h0,        lat: 0, hold: 1, exp: 32'h0000007F};

    // reset: a load presented during reset must not be captured
    rst = 1'b1; flush = 1'b0; stall_drv = 10'h000; data_ok = 1'b0; rdata_in = 32'h0;
    ex_bus = mk_bus(4'd5, 32'h0, 32'h100, 1'b1, 5'd2, 32'h40);
    repeat (2) @(negedge clk);
    #1;
    check("reset wb", mem_to_wb_bus, 274'(0));
    check("reset stallreq", 274'(stallreq_mem), 274'(1'b0));
    check("reset fwd", 274'(mem_fwd_bus), 274'(0));
    rst = 1'b0; ex_bus = '0;
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rdata,
              vecs[i].rt, vecs[i].exp, vecs[i].lat, vecs[i].hold);
      @(negedge clk);
    end

    // non-memop passthrough, stall[7]-only bubble, full stall hold
    alu = mk_bus(4'd0, 32'h0, 32'hCAFE0001, 1'b1, 5'd3, 32'h400);
    ex_bus = alu; stall_drv = 10'h000;
    @(negedge clk);
    ex_bus = mk_bus(4'd0, 32'h0, 32'hBEEF0002, 1'b1, 5'd4, 32'h404); stall_drv = 10'h080; #1;
    check("alu passthrough", mem_to_wb_bus, alu[273:0]);
    check("alu fwd", 274'(mem_fwd_bus), 274'(alu[37:0]));
    @(negedge clk);
    ex_bus = alu; stall_drv = 10'h000; #1;
    check("stall7 bubble", mem_to_wb_bus, 274'(0));
    @(negedge clk);
    ex_bus = mk_bus(4'd0, 32'h0, 32'hBEEF0003, 1'b1, 5'd5, 32'h408); stall_drv = 10'h180;
    @(negedge clk);
    #1;
    check("stall78 hold", mem_to_wb_bus, alu[273:0]);
    stall_drv = 10'h000; ex_bus = '0;
    @(negedge clk);

    // flush while waiting, new load enters, stale response dropped
    lwa = mk_bus(4'd5, 32'h0, 32'h00000100, 1'b1, 5'd8, 32'h500);
    lwb = mk_bus(4'd5, 32'h0, 32'h00000200, 1'b1, 5'd9, 32'h504);
    ex_bus = lwa;
    @(negedge clk);
    ex_bus = '0; flush = 1'b1; #1;
    check("flush wait stallreq", 274'(stallreq_mem), 274'(1'b1));
    @(negedge clk);
    flush = 1'b0; ex_bus = lwb; #1;
    check("drop empty stallreq", 274'(stallreq_mem), 274'(1'b0));
    check("drop empty wb", mem_to_wb_bus, 274'(0));
    @(negedge clk);
    ex_bus = '0; data_ok = 1'b1; rdata_in = 32'h11111111; #1;
    check("drop stale stallreq", 274'(stallreq_mem), 274'(1'b1));
    check("drop stale we", 274'(mem_to_wb_bus[37]), 274'(1'b0));
    @(negedge clk);
    data_ok = 1'b0; rdata_in = 32'h33333333; #1;
    check("wait after drop", 274'(stallreq_mem), 274'(1'b1));
    @(negedge clk);
    data_ok = 1'b1; rdata_in = 32'h22222222; #1;
    exp_b = lwb[273:0]; exp_b[31:0] = 32'h22222222;
    check("drop new resp", mem_to_wb_bus, exp_b);
    @(negedge clk);
    data_ok = 1'b0; #1;
    check("drop bubble", mem_to_wb_bus, 274'(0));
    @(negedge clk);

    // flush together with data_ok: consumed, back to IDLE
    ex_bus = lwa;
    @(negedge clk);
    ex_bus = '0; data_ok = 1'b1; rdata_in = 32'h33333333; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; data_ok = 1'b0; #1;
    check("flush_ok stallreq", 274'(stallreq_mem), 274'(1'b0));
    check("flush_ok wb", mem_to_wb_bus, 274'(0));
    run_txn("after_flush_ok", 4'd5, 32'h00000300, 32'h44444444, 32'h0, 32'h44444444, 0, 0);
    @(negedge clk);

    // reset in the middle of a wait
    ex_bus = lwa;
    @(negedge clk);
    ex_bus = '0; rst = 1'b1; #1;
    check("pre-rst stallreq", 274'(stallreq_mem), 274'(1'b1));
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst wait stallreq", 274'(stallreq_mem), 274'(1'b0));
    check("rst wait wb", mem_to_wb_bus, 274'(0));
    run_txn("after_rst", 4'd1, 32'h00000401, 32'h0000A500, 32'h0, 32'hFFFFFFA5, 1, 0);
    @(negedge clk);

    // randomized loads and stores against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] rd;
      logic [31:0] rt;
      op   = 4'($urandom_range(1, 10));
      addr = $urandom;
      rd   = $urandom;
      rt   = $urandom;
      run_txn($sformatf("rnd%0d_op%0d", k, op), op, addr, rd, rt,
              ref_result(op, addr, rd, rt), $urandom_range(0, 3), $urandom_range(0, 2));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
